// File: rtl/hex_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hex_display                                                  |
// | Description : Registered multi-digit hex driver for active-low 7-segment   |
// |               displays with leading-zero blanking, decimal points and      |
// |               optional blinking (enabled by `define HEX_DISPLAY_BLINK_EN). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hex_display #(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    output logic [8*DIGITS-1:0]   seg,
    output logic                  updated
);

    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   dp_q;
    logic                load_q;
    logic                updated_q;
    logic [8*DIGITS-1:0] seg_q;
    logic [8*DIGITS-1:0] seg_d;
    logic [DIGITS-1:0]   blink_blank;
    logic                seen_nz;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // updated trails load by two edges: one to capture, one to register seg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= '0;
            dp_q      <= '0;
            load_q    <= 1'b0;
            updated_q <= 1'b0;
            seg_q     <= '1;
        end else begin
            load_q    <= load;
            updated_q <= load_q;
            seg_q     <= seg_d;
            if (load) begin
                value_q <= value;
                dp_q    <= dp_in;
            end
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int              CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              phase_q;
    logic              phase_d;
    logic [DIGITS-1:0] mask_q;

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_WRAP) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            if (load) begin
                mask_q <= blink_mask;
            end
        end
    end

    assign blink_blank = phase_q ? mask_q : '0;
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign blink_blank       = '0;
`endif

    // Scan from the most significant digit; digit 0 always counts as significant
    always_comb begin
        seen_nz = 1'b0;
        seg_d   = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (value_q[4*i +: 4] != 4'h0 || i == 0) begin
                seen_nz = 1'b1;
            end
            if (!(blank_lz && !seen_nz) && !blink_blank[i]) begin
                seg_d[8*i +: 8] = {~dp_q[i], hex_to_seg(value_q[4*i +: 4])};
            end
        end
    end

    assign seg     = seg_q;
    assign updated = updated_q;

endmodule
`default_nettype wire
